motor_ramp_ctrl: RTL

//  Parametrised NCH-channel motor drive stage with slew-rate limiting and safe reversal.

---
 rtl/motor_ramp_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/motor_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : motor_ramp_ctrl
// Purpose  : NCH-channel motor drive stage with slew-rate limiting and safe
//            reversal. Each channel's duty moves toward its clamped target by
//            at most STEP per ramp tick. A direction change first ramps to 0,
//            then coasts (IN=2'b00) for DEAD_TICKS ticks, then takes the new
//            direction. estop forces every channel to coast at duty 0 on the
//            next clk.
// Ports    : clk       in   system clock
//            rst       in   asynchronous active-high reset
//            tgt_duty  in   per-channel target duty, ch i at [i*DUTY_W +: DUTY_W]
//            tgt_dir   in   per-channel target direction (1 = fwd, 0 = rev)
//            estop     in   level-sensitive emergency stop, all channels
//            duty_out  out  per-channel applied duty, to motor_pwm
//            dir_in    out  per-channel H-bridge IN pair [2i+1:2i]
//                           (fwd 2'b10, rev 2'b01, coast 2'b00)
//            settled   out  channel at its clamped target in its target dir
// Revision : 1.0  initial release
// ============================================================================
module motor_ramp_ctrl #(
   parameter int NCH        = 2,
   parameter int DUTY_W     = 10,
   parameter int MAX_DUTY   = 1000,
   parameter int STEP       = 50,
   parameter int TICK_DIV   = 100000,
   parameter int DEAD_TICKS = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NCH*DUTY_W-1:0] tgt_duty,
   input  logic [NCH-1:0]        tgt_dir,
   input  logic                  estop,
   output logic [NCH*DUTY_W-1:0] duty_out,
   output logic [2*NCH-1:0]      dir_in,
   output logic [NCH-1:0]        settled
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int DC_W  = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS + 1) : 1;

   localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [DUTY_W-1:0] MAX_D     = DUTY_W'(MAX_DUTY);
   localparam logic [DUTY_W-1:0] STEP_D    = DUTY_W'(STEP);
   localparam logic [DC_W-1:0]   DEAD_D    = DC_W'(DEAD_TICKS);
   localparam logic [DC_W-1:0]   DEAD_ONE  = DC_W'(1);

   localparam logic [1:0] IN_FWD   = 2'b10;
   localparam logic [1:0] IN_REV   = 2'b01;
   localparam logic [1:0] IN_COAST = 2'b00;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_RAMPDN = 2'd1,
      ST_DEAD   = 2'd2
   } state_t;

   // ---------------------------------------------------------------------
   // Shared ramp tick: one-cycle pulse every TICK_DIV clocks, free-running
   // regardless of estop so all channels stay phase-locked to one timebase.
   // ---------------------------------------------------------------------
   logic [CNT_W-1:0] tick_cnt;
   logic             tick;

   assign tick = (tick_cnt == TICK_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       tick_cnt <= '0;
      else if (tick) tick_cnt <= '0;
      else           tick_cnt <= tick_cnt + CNT_W'(1);
   end

   // ---------------------------------------------------------------------
   // Per-channel ramp / reversal FSM
   // ---------------------------------------------------------------------
   for (genvar i = 0; i < NCH; i++) begin : g_ch
      state_t            state, state_nxt;
      logic [DUTY_W-1:0] duty, duty_nxt;
      logic [DUTY_W-1:0] tgt_raw, tgt_c, gap, gap_step, down_step;
      logic              cur_dir, cur_dir_nxt;
      logic [DC_W-1:0]   dead_cnt, dead_cnt_nxt;
      logic [1:0]        in_r;
      logic              settled_r;

      assign tgt_raw   = tgt_duty[i*DUTY_W +: DUTY_W];
      assign tgt_c     = (tgt_raw > MAX_D) ? MAX_D : tgt_raw;
      assign gap       = (tgt_c > duty) ? (tgt_c - duty) : (duty - tgt_c);
      assign gap_step  = (gap > STEP_D) ? STEP_D : gap;      // never overshoot
      assign down_step = (duty > STEP_D) ? STEP_D : duty;    // never below 0

      always_comb begin
         state_nxt    = state;
         duty_nxt     = duty;
         cur_dir_nxt  = cur_dir;
         dead_cnt_nxt = dead_cnt;
         if (estop) begin
            // Checked before tick: estop acts every clk and wins over a tick.
            state_nxt    = ST_DEAD;
            duty_nxt     = '0;
            dead_cnt_nxt = DEAD_D;
         end else if (tick) begin
            case (state)
               ST_RUN: begin
                  if (tgt_dir[i] == cur_dir) begin
                     if (tgt_c > duty) duty_nxt = duty + gap_step;
                     else              duty_nxt = duty - gap_step;
                  end else begin
                     // Reversal request: start the ramp-down on this tick.
                     // A duty already at (or reaching) 0 goes straight to coast.
                     duty_nxt = duty - down_step;
                     if (down_step == duty) begin
                        state_nxt    = ST_DEAD;
                        dead_cnt_nxt = DEAD_D;
                     end else begin
                        state_nxt = ST_RAMPDN;
                     end
                  end
               end
               ST_RAMPDN: begin
                  // Committed to the ramp-down even if tgt_dir flips back.
                  duty_nxt = duty - down_step;
                  if (down_step == duty) begin
                     state_nxt    = ST_DEAD;
                     dead_cnt_nxt = DEAD_D;
                  end
               end
               ST_DEAD: begin
                  if (dead_cnt == DEAD_ONE) begin
                     cur_dir_nxt = tgt_dir[i];
                     state_nxt   = ST_RUN;
                  end else begin
                     dead_cnt_nxt = dead_cnt - DEAD_ONE;
                  end
               end
               default: begin
                  state_nxt    = ST_DEAD;
                  duty_nxt     = '0;
                  dead_cnt_nxt = DEAD_D;
               end
            endcase
         end
      end

      // Outputs are registered from next-state values so they line up with
      // the duty register (estop clears settled and IN on the very next clk).
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            state     <= ST_RUN;
            duty      <= '0;
            cur_dir   <= 1'b1;
            dead_cnt  <= '0;
            in_r      <= IN_FWD;
            settled_r <= 1'b0;
         end else begin
            state     <= state_nxt;
            duty      <= duty_nxt;
            cur_dir   <= cur_dir_nxt;
            dead_cnt  <= dead_cnt_nxt;
            in_r      <= (state_nxt == ST_DEAD) ? IN_COAST :
                         (cur_dir_nxt ? IN_FWD : IN_REV);
            settled_r <= (state_nxt == ST_RUN) && (duty_nxt == tgt_c) &&
                         (tgt_dir[i] == cur_dir_nxt);
         end
      end

      assign duty_out[i*DUTY_W +: DUTY_W] = duty;
      assign dir_in[2*i +: 2]             = in_r;
      assign settled[i]                   = settled_r;
   end

endmodule
`default_nettype wire
